// File: rtl/wb_burst_master.sv
// Wishbone B3 classic-cycle burst initiator: one read or write burst of 1..2**BLW beats at a time.
// Define WB_TIMEOUT_EN to abort a burst whose strobe goes unacknowledged for TIMEOUT cycles.
module wb_burst_master #(
   parameter int AW      = 26,
   parameter int DW      = 32,
   parameter int BLW     = 4,
   parameter int TIMEOUT = 255
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [AW-1:0]     req_addr,
   input  logic [BLW-1:0]    req_len,
   input  logic [DW/8-1:0]   req_sel,
   input  logic [DW-1:0]     wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [DW-1:0]     rd_data,
   output logic              rd_valid,
   output logic              done,
   output logic              err,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [AW-1:0]     wb_adr_o,
   output logic [DW-1:0]     wb_dat_o,
   output logic [DW/8-1:0]   wb_sel_o,
   input  logic [DW-1:0]     wb_dat_i,
   input  logic              wb_ack_i,
   input  logic              wb_err_i
);
   localparam int SW = DW / 8;

   typedef enum logic {IDLE, XFER} state_e;

   state_e          state_q, state_d;
   logic            we_q, we_d, cyc_q, cyc_d, stb_q, stb_d;
   logic            rvld_q, rvld_d, done_q, done_d, err_q, err_d;
   logic [AW-1:0]   adr_q, adr_d;
   logic [SW-1:0]   sel_q, sel_d;
   logic [BLW-1:0]  cnt_q, cnt_d;
   logic [DW-1:0]   dat_q, dat_d, rdat_q, rdat_d;
   logic            ack_ok, err_hit, to_hit, last_beat, wr_load;

   // A simultaneous wb_err_i overrides wb_ack_i, and neither counts without our strobe.
   assign ack_ok    = stb_q & wb_ack_i & ~wb_err_i;
   assign last_beat = (cnt_q == '0);
   assign err_hit   = stb_q & (wb_err_i | to_hit);

`ifdef WB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] to_q, to_d;

   assign to_hit = stb_q & ~wb_ack_i & ~wb_err_i & (to_q == TW'(TIMEOUT - 1));

   always_comb begin
      to_d = to_q;
      if (state_q == IDLE || wb_ack_i || wb_err_i) to_d = '0;
      else if (stb_q)                              to_d = to_q + 1'b1;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) to_q <= '0;
      else          to_q <= to_d;
   end
`else
   assign to_hit = 1'b0;
`endif

   // The done cycle keeps req_ready low, which guarantees a bus-idle gap between bursts.
   assign req_ready = (state_q == IDLE) & ~done_q & ~wb_rst_i;
   assign wr_ready  = (state_q == XFER) & we_q & (~stb_q | (ack_ok & ~last_beat));
   assign wr_load   = wr_valid & wr_ready;

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the case infers a latch.
      state_d = state_q;
      we_d    = we_q;
      adr_d   = adr_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      cyc_d   = cyc_q;
      stb_d   = stb_q;
      dat_d   = dat_q;
      rdat_d  = rdat_q;
      rvld_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               state_d = XFER;
               we_d    = req_we;
               adr_d   = req_addr;
               sel_d   = req_sel;
               cnt_d   = req_len;
               cyc_d   = 1'b1;
               stb_d   = ~req_we;
            end
         end
         XFER: begin
            if (err_hit) begin
               state_d = IDLE;
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end else if (ack_ok && last_beat) begin
               state_d = IDLE;
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               done_d  = 1'b1;
               rvld_d  = ~we_q;
               if (!we_q) rdat_d = wb_dat_i;
            end else begin
               if (ack_ok) begin
                  adr_d  = adr_q + AW'(SW);
                  cnt_d  = cnt_q - 1'b1;
                  rvld_d = ~we_q;
                  if (!we_q) rdat_d = wb_dat_i;
               end
               // Writes insert a wait state (stb low, cyc high) when no beat is ready.
               if (we_q) begin
                  if (wr_load) begin
                     dat_d = wr_data;
                     stb_d = 1'b1;
                  end else if (ack_ok) begin
                     stb_d = 1'b0;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so all registers update from the same pre-edge values.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         adr_q   <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         dat_q   <= '0;
         rdat_q  <= '0;
         rvld_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         cyc_q   <= cyc_d;
         stb_q   <= stb_d;
         dat_q   <= dat_d;
         rdat_q  <= rdat_d;
         rvld_q  <= rvld_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = stb_q;
   assign wb_we_o  = we_q;
   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;
   assign wb_sel_o = sel_q;
   assign rd_data  = rdat_q;
   assign rd_valid = rvld_q;
   assign done     = done_q;
   assign err      = err_q;
endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: one negedge-driven process plays the Wishbone slave,
// the write-beat source and the output monitor; each test task checks its own scenario.
module tb_wb_burst_master;
   localparam int AW = 26;
   localparam int DW = 32;
   localparam int BLW = 4;
   localparam int SW = DW / 8;

   logic            wb_clk_i = 1'b0;
   logic            wb_rst_i = 1'b1;
   logic            req_valid = 1'b0, req_we = 1'b0;
   logic [AW-1:0]   req_addr = '0;
   logic [BLW-1:0]  req_len = '0;
   logic [SW-1:0]   req_sel = '0;
   logic [DW-1:0]   wr_data = '0, wb_dat_i = '0;
   logic            wr_valid = 1'b0, wb_ack_i = 1'b0, wb_err_i = 1'b0;
   logic            req_ready, wr_ready, rd_valid, done, err;
   logic            wb_cyc_o, wb_stb_o, wb_we_o;
   logic [DW-1:0]   rd_data, wb_dat_o;
   logic [AW-1:0]   wb_adr_o;
   logic [SW-1:0]   wb_sel_o;

   wb_burst_master #(.AW(AW), .DW(DW), .BLW(BLW), .TIMEOUT(16)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
      .req_len(req_len), .req_sel(req_sel),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
      .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int tests = 0, fails = 0;
   int cyc_n, waited, s_beat, ack_delay, err_beat, wr_idx, wr_n, gap_beat, gap_left;
   int rd_cnt, done_cnt, err_cnt, cyc_hi, stb_gap, hs_cnt, late_rdy, done_cyc, ack_cyc, stb_rise;
   bit never_ack, drv_ack, wr_hs, prev_done;
   logic rdy_at_done, rdy_after_done, we0;
   logic [SW-1:0] sel0;
   logic [DW-1:0] rd_words[16], dat_log[16], rd_log[16], wdata[16];
   logic [AW-1:0] adr_log[16];

   task automatic clear();
      cyc_n = 0; waited = 0; s_beat = 0; ack_delay = 0; err_beat = -1; never_ack = 0;
      wr_idx = 0; wr_n = 0; gap_beat = -1; gap_left = 0; drv_ack = 0; wr_hs = 0; prev_done = 0;
      rd_cnt = 0; done_cnt = 0; err_cnt = 0; cyc_hi = 0; stb_gap = 0; hs_cnt = 0; late_rdy = 0;
      done_cyc = -1; ack_cyc = -1; stb_rise = -1; rdy_at_done = 1'bx; rdy_after_done = 1'bx;
      we0 = 1'bx; sel0 = 'x;
      for (int i = 0; i < 16; i++) begin
         rd_words[i] = '0; dat_log[i] = '0; rd_log[i] = '0; wdata[i] = '0; adr_log[i] = '0;
      end
   endtask

   // One clock cycle: monitor registered outputs, play the slave and the write source.
   task automatic tick();
      @(negedge wb_clk_i);
      cyc_n++;
      if (drv_ack) begin waited = 0; s_beat++; end
      if (wr_hs) wr_idx++;
      if (rd_valid) begin if (rd_cnt < 16) rd_log[rd_cnt] = rd_data; rd_cnt++; end
      if (done) begin done_cnt++; done_cyc = cyc_n; rdy_at_done = req_ready; end
      if (prev_done) rdy_after_done = req_ready;
      prev_done = done;
      if (err) err_cnt++;
      if (wb_cyc_o) cyc_hi++;
      if (wb_cyc_o && !wb_stb_o) stb_gap++;
      if (wb_stb_o && stb_rise < 0) stb_rise = cyc_n;
      wb_ack_i = 1'b0; wb_err_i = 1'b0;
      if (wb_stb_o && !never_ack) begin
         if (waited == ack_delay) begin
            if (s_beat == err_beat) wb_err_i = 1'b1;
            else begin wb_ack_i = 1'b1; if (s_beat < 16) wb_dat_i = rd_words[s_beat]; end
            if (s_beat < 16) begin adr_log[s_beat] = wb_adr_o; dat_log[s_beat] = wb_dat_o; end
            if (s_beat == 0) begin sel0 = wb_sel_o; we0 = wb_we_o; end
            ack_cyc = cyc_n;
         end else waited++;
      end else waited = 0;
      wr_valid = 1'b0;
      if (wr_idx < wr_n) begin
         if (wr_idx == gap_beat && gap_left > 0) gap_left--;
         else begin wr_valid = 1'b1; wr_data = wdata[wr_idx]; end
      end
      #1;
      drv_ack = wb_ack_i | wb_err_i;
      wr_hs = wr_valid & wr_ready;
      if (wr_hs) hs_cnt++;
      if (wr_ready && wr_idx >= wr_n) late_rdy++;
   endtask

   task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [BLW-1:0] len,
                        input logic [SW-1:0] sel, input string name);
      bit got = 0;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_len = len; req_sel = sel;
      for (int i = 0; i < 20 && !got; i++) begin got = req_ready; tick(); end
      req_valid = 1'b0;
      tests++; if (!got) begin fails++; $display("FAIL %s_accept: req_ready never seen", name); end
   endtask

   task automatic wait_done(input int limit, input string name);
      int n = 0;
      while (done_cnt == 0 && n < limit) begin tick(); n++; end
      tests++; if (done_cnt == 0) begin fails++; $display("FAIL %s_done: no done within %0d cycles", name, limit); end
      tick(); tick();
   endtask

   task automatic test_reset();
      logic [15:0] outs;
      clear();
      repeat (3) tick();
      outs = {wb_cyc_o, wb_stb_o, wb_we_o, |wb_adr_o, |wb_dat_o, |wb_sel_o, |rd_data,
              rd_valid, done, err, req_ready, wr_ready, 4'b0};
      tests++; if (outs !== '0) begin fails++; $display("FAIL reset_outputs: got %h, want 0000", outs); end
      wb_rst_i = 1'b0;
      tick();
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b, want 1", req_ready); end
   endtask

   task automatic test_single_read();
      clear(); ack_delay = 2; rd_words[0] = 32'hDEADBEEF;
      issue(1'b0, 26'h100, 4'd0, 4'hF, "rd1");
      wait_done(20, "rd1");
      tests++; if (rd_cnt !== 1) begin fails++; $display("FAIL rd1_count: got %0d, want 1", rd_cnt); end
      tests++; if (rd_log[0] !== 32'hDEADBEEF) begin fails++; $display("FAIL rd1_data: got %h, want deadbeef", rd_log[0]); end
      tests++; if (adr_log[0] !== 26'h100 || we0 !== 1'b0) begin fails++; $display("FAIL rd1_adr: got %h we %b, want 100 we 0", adr_log[0], we0); end
      tests++; if (cyc_hi !== 3) begin fails++; $display("FAIL rd1_cyc_len: got %0d, want 3", cyc_hi); end
      tests++; if (done_cyc - ack_cyc !== 1) begin fails++; $display("FAIL rd1_done_lat: got %0d, want 1", done_cyc - ack_cyc); end
      tests++; if (err_cnt !== 0 || done_cnt !== 1) begin fails++; $display("FAIL rd1_status: got done %0d err %0d, want 1 0", done_cnt, err_cnt); end
   endtask

   task automatic test_write_gap();
      clear(); wr_n = 4; gap_beat = 2; gap_left = 2;
      wdata[0] = 32'h11; wdata[1] = 32'h22; wdata[2] = 32'h33; wdata[3] = 32'h44;
      issue(1'b1, 26'h200, 4'd3, 4'hF, "wr4");
      wait_done(40, "wr4");
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (adr_log[i] !== 26'h200 + 26'(4 * i) || dat_log[i] !== wdata[i]) begin
            fails++; $display("FAIL wr4_beat%0d: got adr %h dat %h, want %h %h", i, adr_log[i], dat_log[i], 26'h200 + 26'(4 * i), wdata[i]);
         end
      end
      tests++; if (hs_cnt !== 4) begin fails++; $display("FAIL wr4_handshakes: got %0d, want 4", hs_cnt); end
      tests++; if (late_rdy !== 0) begin fails++; $display("FAIL wr4_late_ready: got %0d, want 0", late_rdy); end
      // One wait cycle before beat 0 plus the two-cycle source gap, all with cyc held high.
      tests++; if (stb_gap !== 3 || cyc_hi !== 7) begin fails++; $display("FAIL wr4_gap: got stb_gap %0d cyc %0d, want 3 7", stb_gap, cyc_hi); end
      tests++; if (we0 !== 1'b1 || sel0 !== 4'hF) begin fails++; $display("FAIL wr4_we_sel: got %b %h, want 1 f", we0, sel0); end
      tests++; if (done_cnt !== 1 || err_cnt !== 0) begin fails++; $display("FAIL wr4_status: got done %0d err %0d, want 1 0", done_cnt, err_cnt); end
   endtask

   task automatic test_read_error();
      clear(); err_beat = 2;
      for (int i = 0; i < 8; i++) rd_words[i] = 32'hA000_0000 + 32'(i);
      issue(1'b0, 26'h300, 4'd7, 4'hF, "rderr");
      wait_done(30, "rderr");
      tests++; if (rd_cnt !== 2 || rd_log[1] !== 32'hA000_0001) begin fails++; $display("FAIL rderr_beats: got %0d last %h, want 2 a0000001", rd_cnt, rd_log[1]); end
      tests++; if (done_cnt !== 1 || err_cnt !== 1) begin fails++; $display("FAIL rderr_status: got done %0d err %0d, want 1 1", done_cnt, err_cnt); end
      tests++; if (cyc_hi !== 3) begin fails++; $display("FAIL rderr_cyc_len: got %0d, want 3", cyc_hi); end
      tests++; if (rdy_at_done !== 1'b0 || rdy_after_done !== 1'b1) begin fails++; $display("FAIL rderr_ready: got %b%b, want 01", rdy_at_done, rdy_after_done); end
   endtask

   task automatic test_reset_mid_burst();
      int n = 0;
      clear(); ack_delay = 1; wr_n = 4;
      for (int i = 0; i < 4; i++) wdata[i] = 32'hB0 + 32'(i);
      issue(1'b1, 26'h400, 4'd3, 4'hF, "rst");
      while (!(s_beat == 1 && wb_stb_o) && n < 30) begin tick(); n++; end
      #1 wb_rst_i = 1'b1;
      #1;
      tests++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_adr_o !== '0) begin fails++; $display("FAIL rst_async: got cyc %b stb %b adr %h, want 0 0 0", wb_cyc_o, wb_stb_o, wb_adr_o); end
      tick(); tick();
      wb_rst_i = 1'b0;
      repeat (3) tick();
      tests++; if (done_cnt !== 0 || err_cnt !== 0) begin fails++; $display("FAIL rst_no_done: got done %0d err %0d, want 0 0", done_cnt, err_cnt); end
      clear(); ack_delay = 1; rd_words[0] = 32'hCAFEF00D;
      issue(1'b0, 26'h40, 4'd0, 4'hF, "rst_after");
      wait_done(20, "rst_after");
      tests++; if (rd_log[0] !== 32'hCAFEF00D || done_cnt !== 1 || err_cnt !== 0) begin fails++; $display("FAIL rst_after: got %h done %0d err %0d, want cafef00d 1 0", rd_log[0], done_cnt, err_cnt); end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] exp_adr[4];
      clear();
      exp_adr[0] = 26'h3FF_FFF8; exp_adr[1] = 26'h3FF_FFFC; exp_adr[2] = 26'h0; exp_adr[3] = 26'h4;
      for (int i = 0; i < 4; i++) rd_words[i] = 32'h5500_0000 + 32'(i);
      issue(1'b0, 26'h3FF_FFF8, 4'd3, 4'h3, "wrap");
      wait_done(20, "wrap");
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (adr_log[i] !== exp_adr[i] || rd_log[i] !== 32'h5500_0000 + 32'(i)) begin
            fails++; $display("FAIL wrap_beat%0d: got adr %h dat %h, want %h %h", i, adr_log[i], rd_log[i], exp_adr[i], 32'h5500_0000 + 32'(i));
         end
      end
      tests++; if (rd_cnt !== 4 || sel0 !== 4'h3) begin fails++; $display("FAIL wrap_count_sel: got %0d %h, want 4 3", rd_cnt, sel0); end
   endtask

   task automatic test_timeout();
      clear(); never_ack = 1;
      issue(1'b0, 26'h500, 4'd0, 4'hF, "tmo");
`ifdef WB_TIMEOUT_EN
      wait_done(40, "tmo");
      tests++; if (done_cyc - stb_rise !== 16 || err_cnt !== 1) begin fails++; $display("FAIL tmo_abort: got %0d cycles err %0d, want 16 1", done_cyc - stb_rise, err_cnt); end
`else
      repeat (300) tick();
      tests++; if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || done_cnt !== 0) begin fails++; $display("FAIL tmo_hold: got cyc %b stb %b done %0d, want 1 1 0", wb_cyc_o, wb_stb_o, done_cnt); end
      wb_rst_i = 1'b1; tick(); tick(); wb_rst_i = 1'b0; tick();
`endif
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write_gap();
      test_read_error();
      test_reset_mid_burst();
      test_wrap();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
